// File: rtl/uart_tx.sv
// UART transmitter: start bit, D_BIT data bits LSB first, optional parity, stop bit(s).
// Bit timing is 16 baud ticks per bit; the stop field lasts SB_TICK ticks.
module uart_tx #(
    parameter int unsigned D_BIT      = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_s_tick,
    input  logic             i_tx_start,
    input  logic [D_BIT-1:0] i_data,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_tx_done_tick
);

    localparam int unsigned TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned TW       = $clog2(TICK_MAX);
    localparam int unsigned BW       = (D_BIT > 1) ? $clog2(D_BIT) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(15);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(D_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [TW-1:0]    tick_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [D_BIT-1:0] shift;
    logic             parity;
    logic             tx;
    logic             busy;
    logic             done;

    // Line level is loaded one edge ahead of each state change so the pin stays a pure flop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (i_tx_start) begin
                        shift    <= i_data;
                        parity   <= (^i_data) ^ (PARITY_ODD != 0);
                        tick_cnt <= '0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (i_s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                            tx       <= shift[0];
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shift    <= shift >> 1;
                            if (bit_cnt == DATA_LAST) begin
                                if (PARITY_EN != 0) begin
                                    state <= PARITY;
                                    tx    <= parity;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                tx      <= shift[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (i_s_tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (i_s_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx           = tx;
    assign o_busy         = busy;
    assign o_tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations, table-driven frame vectors,
// hand-written corner sequences and a loopback through a 16x receiver model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tick;
    logic [3:0] start;
    logic [7:0] data;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7 data bits with 2 stop bits
    uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_tx_start(start[0]),
        .i_data(data), .o_tx(tx[0]), .o_busy(busy[0]), .o_tx_done_tick(done[0]));
    uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_tx_start(start[1]),
        .i_data(data), .o_tx(tx[1]), .o_busy(busy[1]), .o_tx_done_tick(done[1]));
    uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_tx_start(start[2]),
        .i_data(data), .o_tx(tx[2]), .o_busy(busy[2]), .o_tx_done_tick(done[2]));
    uart_tx #(.D_BIT(7), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_7n2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(s_tick), .i_tx_start(start[3]),
        .i_data(data[6:0]), .o_tx(tx[3]), .o_busy(busy[3]), .o_tx_done_tick(done[3]));

    // 16x oversampling receiver on the 8N1 line, sampling mid-bit
    int         rx_st;
    int         rx_t;
    int         rx_nb;
    logic [7:0] rx_sh;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_ferr;
    int         rx_cnt   = 0;
    int         done_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st   <= 0;
            rx_t    <= 0;
            rx_nb   <= 0;
            rx_sh   <= 8'h00;
            rx_data <= 8'h00;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (s_tick) begin
                case (rx_st)
                    0: if (tx[0] == 1'b0) begin rx_st <= 1; rx_t <= 0; end
                    1: if (rx_t == 7) begin rx_st <= 2; rx_t <= 0; rx_nb <= 0; end
                       else rx_t <= rx_t + 1;
                    2: if (rx_t == 15) begin
                           rx_t  <= 0;
                           rx_sh <= {tx[0], rx_sh[7:1]};
                           if (rx_nb == 7) rx_st <= 3;
                           else rx_nb <= rx_nb + 1;
                       end else rx_t <= rx_t + 1;
                    default: if (rx_t == 15) begin
                           rx_st   <= 0;
                           rx_t    <= 0;
                           rx_done <= 1'b1;
                           rx_data <= rx_sh;
                           if (tx[0] !== 1'b1) rx_ferr <= 1'b1;
                       end else rx_t <= rx_t + 1;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (rx_done) rx_cnt <= rx_cnt + 1;
        if (done[0]) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int          sel;
        logic [7:0]  d;
        int          nlev;
        logic [15:0] lev;
        int          stop_ticks;
        int          exp_ticks;
        int          period;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input int sel, input logic [7:0] d, input string tag);
        data       = d;
        start[sel] = 1'b1;
        @(posedge clk);
        #1;
        start[sel] = 1'b0;
        check({tag, " start_low"}, 32'(tx[sel]), 32'd0);
        check({tag, " busy_set"}, 32'(busy[sel]), 32'd1);
    endtask

    // Walk the frame tick by tick; lev[i] is the expected line level of field i.
    task automatic run_levels(input int sel, input int nlev, input logic [15:0] lev,
                              input int stop_ticks, input int period, input int exp_ticks,
                              input int inject_at, input string tag);
        int t;
        int done_at;
        int total;
        bit busy_ok;
        bit extra;
        t       = 0;
        done_at = -1;
        busy_ok = 1'b1;
        extra   = 1'b0;
        total   = 16 * (nlev - 1) + stop_ticks;
        for (int i = 0; i < nlev; i++) begin
            int len;
            bit ok;
            len = (i == nlev - 1) ? stop_ticks : 16;
            ok  = 1'b1;
            for (int k = 0; k < len; k++) begin
                if (tx[sel] !== lev[i]) ok = 1'b0;
                if (t == inject_at) begin
                    data       = 8'h3C;
                    start[sel] = 1'b1;
                end
                s_tick = 1'b1;
                @(posedge clk);
                #1;
                s_tick     = 1'b0;
                start[sel] = 1'b0;
                t++;
                if (done[sel] === 1'b1 && done_at < 0) done_at = t;
                if (t < total) begin
                    if (busy[sel] !== 1'b1) busy_ok = 1'b0;
                    repeat (period - 1) begin
                        @(posedge clk);
                        #1;
                        if (done[sel] !== 1'b0) extra = 1'b1;
                        if (busy[sel] !== 1'b1) busy_ok = 1'b0;
                    end
                end
            end
            check($sformatf("%s level%0d", tag, i), 32'(ok), 32'd1);
        end
        check({tag, " done_tick_at"}, 32'(done_at), 32'(exp_ticks));
        check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, " no_stray_done"}, 32'(extra), 32'd0);
        check({tag, " busy_clear"}, 32'(busy[sel]), 32'd0);
        check({tag, " tx_idle"}, 32'(tx[sel]), 32'd1);
    endtask

    task automatic idle_check(input int sel, input int n, input string tag);
        bit ok;
        ok = 1'b1;
        repeat (n) begin
            s_tick = 1'b1;
            @(posedge clk);
            #1;
            if (tx[sel] !== 1'b1 || busy[sel] !== 1'b0 || done[sel] !== 1'b0) ok = 1'b0;
        end
        s_tick = 1'b0;
        check({tag, " idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int r0;

        // field levels written MSB..LSB: stop, [parity], data[msb..lsb], start
        vecs[0] = '{0, 8'hA5, 10, 16'b1101001010,  16, 160, 4};
        vecs[1] = '{1, 8'hA5, 11, 16'b10101001010, 16, 176, 4};
        vecs[2] = '{2, 8'hA5, 11, 16'b11101001010, 16, 176, 2};
        vecs[3] = '{1, 8'h01, 11, 16'b11000000010, 16, 176, 1};
        vecs[4] = '{3, 8'h7F, 9,  16'b111111110,   32, 160, 4};
        vecs[5] = '{0, 8'h00, 10, 16'b1000000000,  16, 160, 1};
        vecs[6] = '{0, 8'hFF, 10, 16'b1111111110,  16, 160, 2};
        vecs[7] = '{2, 8'h00, 11, 16'b11000000000, 16, 176, 4};

        rst_n  = 1'b0;
        s_tick = 1'b0;
        start  = 4'h0;
        data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx), 32'hF);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        rst_n = 1'b1;
        idle_check(0, 20, "post_reset");

        foreach (vecs[i]) begin
            start_frame(vecs[i].sel, vecs[i].d, $sformatf("vec%0d", i));
            run_levels(vecs[i].sel, vecs[i].nlev, vecs[i].lev, vecs[i].stop_ticks,
                       vecs[i].period, vecs[i].exp_ticks, -1, $sformatf("vec%0d", i));
            idle_check(vecs[i].sel, 4, $sformatf("vec%0d", i));
        end

        // start request during DATA is dropped and never queued
        start_frame(0, 8'hA5, "reject");
        run_levels(0, 10, 16'b1101001010, 16, 4, 160, 50, "reject");
        idle_check(0, 400, "reject");

        // start coincident with the final stop tick is ignored
        start_frame(0, 8'hA5, "coinc");
        run_levels(0, 10, 16'b1101001010, 16, 4, 160, 159, "coinc");
        idle_check(0, 200, "coinc");

        // start in the clock the done pulse is visible begins the next frame at once
        start_frame(0, 8'hA5, "b2b_a");
        run_levels(0, 10, 16'b1101001010, 16, 4, 160, -1, "b2b_a");
        start_frame(0, 8'h55, "b2b_b");
        run_levels(0, 10, 16'b1010101010, 16, 4, 160, -1, "b2b_b");
        idle_check(0, 4, "b2b_b");

        // asynchronous reset in the middle of data bit 1 (a zero for 0xA5)
        start_frame(0, 8'hA5, "areset");
        repeat (40) begin
            s_tick = 1'b1;
            @(posedge clk);
            #1;
            s_tick = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        check("areset pre_tx", 32'(tx[0]), 32'd0);
        check("areset pre_busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset tx_now", 32'(tx[0]), 32'd1);
        check("areset busy_now", 32'(busy[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_check(0, 100, "areset");

        // loopback of every byte through the receiver model, tick held high
        d0 = done_cnt;
        r0 = rx_cnt;
        for (int v = 0; v < 256; v++) begin
            start_frame(0, 8'(v), "lb");
            repeat (160) begin
                s_tick = 1'b1;
                @(posedge clk);
                #1;
            end
            s_tick = 1'b0;
            check($sformatf("lb done %0h", v), 32'(done[0]), 32'd1);
            check($sformatf("lb data %0h", v), 32'(rx_data), 32'(v));
        end
        idle_check(0, 4, "lb");
        check("lb tx_done_count", 32'(done_cnt - d0), 32'd256);
        check("lb rx_done_count", 32'(rx_cnt - r0), 32'd256);
        check("lb framing", 32'(rx_ferr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
